// File: rtl/gpio_pad_bank.sv
// gpio_pad_bank: pad-side GPIO bank sitting between the SoC GPIO controller
// and FPGA IOBUF primitives. Each channel has a registered output path with a
// selectable drive mode, a 2-FF input synchroniser, a counter-based glitch
// filter, edge detection and a sticky interrupt pending bit.
//
// Ports:
//   io_clock, io_reset        clock, synchronous active-high reset
//   io_pins_write/_writeEnable output value / drive request from controller
//   io_pins_read              filtered input level to controller
//   io_mode                   2 bits per channel: 00 push-pull, 01 open-drain,
//                             10/11 input-only
//   io_irqRiseEnable/FallEnable edge qualifiers for pending
//   io_irqClear               per-bit pending clear
//   io_irqPending, io_irq     sticky pending bits and their OR
//   io_rise, io_fall          1-cycle pulses on filtered edges
//   pad_i, pad_o, pad_t       IOBUF O, I, T (pad_t=1 means high-Z)
module gpio_pad_bank #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        RESET_LEVEL   = 1'b1
) (
  input  logic                 io_clock,
  input  logic                 io_reset,
  input  logic [WIDTH-1:0]     io_pins_write,
  input  logic [WIDTH-1:0]     io_pins_writeEnable,
  output logic [WIDTH-1:0]     io_pins_read,
  input  logic [2*WIDTH-1:0]   io_mode,
  input  logic [WIDTH-1:0]     io_irqRiseEnable,
  input  logic [WIDTH-1:0]     io_irqFallEnable,
  input  logic [WIDTH-1:0]     io_irqClear,
  output logic [WIDTH-1:0]     io_irqPending,
  output logic                 io_irq,
  output logic [WIDTH-1:0]     io_rise,
  output logic [WIDTH-1:0]     io_fall,
  input  logic [WIDTH-1:0]     pad_i,
  output logic [WIDTH-1:0]     pad_o,
  output logic [WIDTH-1:0]     pad_t
);

  localparam int unsigned CNT_W   = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
  localparam logic [WIDTH-1:0] LVL_RST  = {WIDTH{RESET_LEVEL}};

  logic [WIDTH-1:0] pad_o_q, pad_o_d;
  logic [WIDTH-1:0] pad_t_q, pad_t_d;
  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] filt_q, filt_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Output drive per mode
  always_comb begin
    pad_o_d = '0;
    pad_t_d = '1;
    for (int i = 0; i < WIDTH; i++) begin
      unique case (io_mode[2*i +: 2])
        2'b00: begin
          pad_o_d[i] = io_pins_write[i];
          pad_t_d[i] = ~io_pins_writeEnable[i];
        end
        2'b01: begin
          // Open-drain: only ever drive low, release for a 1
          pad_o_d[i] = 1'b0;
          pad_t_d[i] = ~(io_pins_writeEnable[i] & ~io_pins_write[i]);
        end
        default: begin
          pad_o_d[i] = 1'b0;
          pad_t_d[i] = 1'b1;
        end
      endcase
    end
  end

  // Synchroniser, glitch filter, edge detect and pending
  always_comb begin
    sync1_d = pad_i;
    sync2_d = sync1_q;
    filt_d  = filt_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    rise_d = filt_d & ~filt_q;
    fall_d = ~filt_d & filt_q;
    // Set takes priority over a simultaneous clear
    pend_d = (rise_d & io_irqRiseEnable) | (fall_d & io_irqFallEnable) |
             (pend_q & ~io_irqClear);
    irq_d  = |pend_d;
  end

  always_ff @(posedge io_clock) begin
    if (io_reset) begin
      pad_o_q <= '0;
      pad_t_q <= '1;
      sync1_q <= LVL_RST;
      sync2_q <= LVL_RST;
      filt_q  <= LVL_RST;
      rise_q  <= '0;
      fall_q  <= '0;
      pend_q  <= '0;
      irq_q   <= 1'b0;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      pad_o_q <= pad_o_d;
      pad_t_q <= pad_t_d;
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      filt_q  <= filt_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      pend_q  <= pend_d;
      irq_q   <= irq_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign pad_o         = pad_o_q;
  assign pad_t         = pad_t_q;
  assign io_pins_read  = filt_q;
  assign io_rise       = rise_q;
  assign io_fall       = fall_q;
  assign io_irqPending = pend_q;
  assign io_irq        = irq_q;

endmodule

// File: tb/tb_gpio_pad_bank.sv
// Scoreboard bench for gpio_pad_bank (WIDTH=4, FILTER_CYCLES=4, RESET_LEVEL=1).
// Stimulus pushes expected output values tagged with the cycle they must
// appear in; the monitor compares them on the falling edge of that cycle.
module tb_gpio_pad_bank;

  localparam int SIG_PAD_T = 0;
  localparam int SIG_PAD_O = 1;
  localparam int SIG_READ  = 2;
  localparam int SIG_PEND  = 3;
  localparam int SIG_IRQ   = 4;
  localparam int SIG_RISE  = 5;
  localparam int SIG_FALL  = 6;

  typedef struct {
    int         cyc;
    int         sig;
    logic [3:0] val;
    logic [3:0] mask;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] wr, we, rd, re, fe, clr, pend, rise, fall, pad_i, pad_o, pad_t;
  logic [7:0] mode;
  logic       irq;

  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;
  exp_t sb[$];

  gpio_pad_bank #(.WIDTH(4), .FILTER_CYCLES(4), .RESET_LEVEL(1'b1)) dut (
    .io_clock(clk), .io_reset(rst),
    .io_pins_write(wr), .io_pins_writeEnable(we), .io_pins_read(rd),
    .io_mode(mode),
    .io_irqRiseEnable(re), .io_irqFallEnable(fe), .io_irqClear(clr),
    .io_irqPending(pend), .io_irq(irq),
    .io_rise(rise), .io_fall(fall),
    .pad_i(pad_i), .pad_o(pad_o), .pad_t(pad_t)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [3:0] actual(int sig);
    case (sig)
      SIG_PAD_T: return pad_t;
      SIG_PAD_O: return pad_o;
      SIG_READ:  return rd;
      SIG_PEND:  return pend;
      SIG_IRQ:   return {3'b000, irq};
      SIG_RISE:  return rise;
      default:   return fall;
    endcase
  endfunction

  task automatic expect_at(input int k, input int sig, input logic [3:0] val,
                           input logic [3:0] mask, input string nm);
    exp_t e;
    e.cyc = cyc + k; e.sig = sig; e.val = val; e.mask = mask; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Monitor: compare every expectation due in this cycle
  always @(negedge clk) begin
    logic [3:0] a;
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        a = actual(sb[i].sig);
        checks = checks + 1;
        if (sb[i].cyc < cyc) begin
          errors = errors + 1;
          $display("FAIL %s: expectation for cycle %0d not checked", sb[i].nm, sb[i].cyc);
        end else if ((a & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
          errors = errors + 1;
          $display("FAIL %s @cyc %0d: got %b, expected %b (mask %b)",
                   sb[i].nm, cyc, a, sb[i].val, sb[i].mask);
        end
        sb.delete(i);
      end
    end
    if (done || cyc > 3000) begin
      if (!done) begin
        errors = errors + 1;
        $display("FAIL watchdog: stimulus did not complete by cycle %0d", cyc);
      end
      if (sb.size() != 0) begin
        errors = errors + 1;
        $display("FAIL leftover: %0d expectations never checked", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  initial begin
    rst = 1'b1; pad_i = 4'b0000; we = 4'b1111; wr = 4'b0000; mode = 8'h00;
    re = 4'b0000; fe = 4'b0000; clr = 4'b0000;

    // Reset held for two edges
    tick(1);
    expect_at(1, SIG_PAD_T, 4'b1111, 4'hF, "rst_pad_t");
    expect_at(1, SIG_PAD_O, 4'b0000, 4'hF, "rst_pad_o");
    expect_at(1, SIG_READ,  4'b1111, 4'hF, "rst_read");
    expect_at(1, SIG_PEND,  4'b0000, 4'hF, "rst_pend");
    expect_at(1, SIG_IRQ,   4'b0000, 4'hF, "rst_irq");
    expect_at(1, SIG_RISE,  4'b0000, 4'hF, "rst_rise");
    expect_at(1, SIG_FALL,  4'b0000, 4'hF, "rst_fall");
    tick(1);
    rst = 1'b0;
    expect_at(1, SIG_PAD_T, 4'b0000, 4'hF, "pp_drive_after_rst");
    expect_at(5, SIG_READ,  4'b1111, 4'hF, "rel_read_hold");
    expect_at(5, SIG_FALL,  4'b0000, 4'hF, "rel_fall_early");
    expect_at(6, SIG_READ,  4'b0000, 4'hF, "rel_read_fall");
    expect_at(6, SIG_FALL,  4'b1111, 4'hF, "rel_fall_pulse");
    expect_at(7, SIG_FALL,  4'b0000, 4'hF, "rel_fall_end");
    expect_at(7, SIG_PEND,  4'b0000, 4'hF, "rel_no_pend");
    tick(8);

    // Output modes: ch0 push-pull, ch1 open-drain, ch2 input, ch3 reserved
    mode = 8'b11_10_01_00; wr = 4'b0101; we = 4'b1111;
    expect_at(1, SIG_PAD_T, 4'b1100, 4'hF, "modes_pad_t");
    expect_at(1, SIG_PAD_O, 4'b0001, 4'hF, "modes_pad_o");
    tick(1);
    wr = 4'b0111;
    expect_at(1, SIG_PAD_T, 4'b1110, 4'hF, "od_release_pad_t");
    expect_at(1, SIG_PAD_O, 4'b0001, 4'hF, "od_release_pad_o");
    tick(1);
    we = 4'b1110;
    expect_at(1, SIG_PAD_T, 4'b1111, 4'hF, "pp_we_low_pad_t");
    tick(1);

    // Bring ch0 high
    pad_i = 4'b0001;
    expect_at(5, SIG_READ, 4'b0000, 4'b0001, "ch0_rise_wait");
    expect_at(6, SIG_READ, 4'b0001, 4'b0001, "ch0_rise_read");
    expect_at(6, SIG_RISE, 4'b0001, 4'hF,    "ch0_rise_pulse");
    tick(8);

    // 3-cycle low glitch is rejected
    for (int k = 1; k <= 10; k++) begin
      expect_at(k, SIG_READ, 4'b0001, 4'b0001, "glitch3_read");
      expect_at(k, SIG_FALL, 4'b0000, 4'b0001, "glitch3_fall");
    end
    pad_i = 4'b0000;
    tick(3);
    pad_i = 4'b0001;
    tick(8);

    // 4-cycle low pulse passes the filter, then re-filters back high
    expect_at(5,  SIG_READ, 4'b0001, 4'b0001, "pulse4_read_pre");
    expect_at(6,  SIG_READ, 4'b0000, 4'b0001, "pulse4_read_low");
    expect_at(9,  SIG_READ, 4'b0000, 4'b0001, "pulse4_read_low_end");
    expect_at(10, SIG_READ, 4'b0001, 4'b0001, "pulse4_read_high");
    expect_at(5,  SIG_FALL, 4'b0000, 4'hF,    "pulse4_fall_pre");
    expect_at(6,  SIG_FALL, 4'b0001, 4'hF,    "pulse4_fall");
    expect_at(7,  SIG_FALL, 4'b0000, 4'hF,    "pulse4_fall_post");
    expect_at(9,  SIG_RISE, 4'b0000, 4'hF,    "pulse4_rise_pre");
    expect_at(10, SIG_RISE, 4'b0001, 4'hF,    "pulse4_rise");
    expect_at(11, SIG_RISE, 4'b0000, 4'hF,    "pulse4_rise_post");
    pad_i = 4'b0000;
    tick(4);
    pad_i = 4'b0001;
    tick(10);

    // Interrupt on rise, fall ignored without enable, then clear
    pad_i = 4'b0000;
    tick(8);
    re = 4'b0001; pad_i = 4'b0001;
    expect_at(5, SIG_PEND, 4'b0000, 4'hF, "irq_pend_pre");
    expect_at(5, SIG_IRQ,  4'b0000, 4'hF, "irq_pre");
    expect_at(6, SIG_PEND, 4'b0001, 4'hF, "irq_pend_set");
    expect_at(6, SIG_IRQ,  4'b0001, 4'hF, "irq_set");
    tick(8);
    pad_i = 4'b0000;
    expect_at(6, SIG_FALL, 4'b0001, 4'hF, "irq_fall_seen");
    expect_at(7, SIG_PEND, 4'b0001, 4'hF, "irq_fall_no_effect");
    expect_at(7, SIG_IRQ,  4'b0001, 4'hF, "irq_still_set");
    tick(8);
    clr = 4'b0001;
    expect_at(1, SIG_PEND, 4'b0000, 4'hF, "irq_clear_pend");
    expect_at(1, SIG_IRQ,  4'b0000, 4'hF, "irq_clear_irq");
    tick(1);
    clr = 4'b0000;
    tick(1);

    // Set wins over a continuously held clear
    clr = 4'b0001; pad_i = 4'b0001;
    expect_at(5, SIG_PEND, 4'b0000, 4'hF, "coll_pend_pre");
    expect_at(6, SIG_PEND, 4'b0001, 4'hF, "coll_pend_set");
    expect_at(6, SIG_IRQ,  4'b0001, 4'hF, "coll_irq_set");
    expect_at(7, SIG_PEND, 4'b0000, 4'hF, "coll_pend_cleared");
    expect_at(7, SIG_IRQ,  4'b0000, 4'hF, "coll_irq_cleared");
    tick(8);
    clr = 4'b0000; re = 4'b0000;

    // Reset mid-filter on ch2 discards the partial count
    pad_i = 4'b0101;
    tick(8);
    pad_i = 4'b0001;
    expect_at(4, SIG_READ, 4'b0100, 4'b0100, "midrst_read_pre");
    tick(4);
    rst = 1'b1;
    expect_at(1, SIG_READ,  4'b1111, 4'hF, "midrst_read");
    expect_at(1, SIG_PEND,  4'b0000, 4'hF, "midrst_pend");
    expect_at(1, SIG_PAD_T, 4'b1111, 4'hF, "midrst_pad_t");
    expect_at(1, SIG_PAD_O, 4'b0000, 4'hF, "midrst_pad_o");
    tick(1);
    rst = 1'b0;
    expect_at(5, SIG_READ, 4'b0100, 4'b0100, "midrst_full_delay");
    expect_at(5, SIG_FALL, 4'b0000, 4'hF,    "midrst_fall_early");
    expect_at(6, SIG_READ, 4'b0001, 4'hF,    "midrst_read_fall");
    expect_at(6, SIG_FALL, 4'b1110, 4'hF,    "midrst_fall_pulse");
    tick(10);
    done = 1'b1;
  end

endmodule
